// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run controller.
// Holds the FSM state enum, default parameters and the PC sentinel.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_RUN,
    S_DREQ,
    S_DWAIT,
    S_DOUT,
    S_DONE
  } state_t;

  localparam int HALT_STABLE_D = 10;
  localparam int TIMEOUT_D     = 1000;
  localparam int DUMP_BASE_D   = 0;
  localparam int DUMP_WORDS_D  = 10;
  localparam int ADDR_W_D      = 8;

  localparam logic [31:0] PC_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_detector.sv
// Detects a PC self-loop: pulses halted when the PC has been unchanged long enough.
// Ports: clk, reset, clear (restart), en (core running), pc in; halted out.
module halt_detector
  import cpu_run_pkg::*;
#(
  parameter int HALT_STABLE = HALT_STABLE_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] pc,
  output logic        halted
);

  localparam int CW = $clog2(HALT_STABLE + 1);
  localparam logic [CW-1:0] MAXC = CW'(HALT_STABLE);

  logic [31:0]   prev_pc;
  logic [CW-1:0] stable_cnt;
  logic          same;

  assign same = (pc == prev_pc);

  // The incremented count reaching HALT_STABLE is the halt condition.
  assign halted = en && same && (stable_cnt == MAXC - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_pc    <= PC_INIT;
      stable_cnt <= '0;
    end else if (en) begin
      prev_pc <= pc;
      if (!same)
        stable_cnt <= '0;
      else if (stable_cnt != MAXC)
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets, runs, detects halt/timeout, then streams a dmem window.
// Ports: clk/reset/start, cpu_pc/cpu_reset/cpu_run, dbg_* read port, out_* stream, busy/done/timeout.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int HALT_STABLE = HALT_STABLE_D,
  parameter int TIMEOUT     = TIMEOUT_D,
  parameter int DUMP_BASE   = DUMP_BASE_D,
  parameter int DUMP_WORDS  = DUMP_WORDS_D,
  parameter int ADDR_W      = ADDR_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       cpu_pc,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              dbg_req,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0]     RUN_LAST = RW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_BASE = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] IDX_LAST =
    ADDR_W'(DUMP_BASE + DUMP_WORDS - 1);

  state_t            state;
  state_t            nxt;
  logic [RW-1:0]     run_cnt;
  logic [ADDR_W-1:0] idx;
  logic              halted;
  logic              at_last;

  assign at_last = (idx == IDX_LAST);

  halt_detector #(
    .HALT_STABLE(HALT_STABLE)
  ) u_halt (
    .clk   (clk),
    .reset (reset),
    .clear (state == S_PRE),
    .en    (state == S_RUN),
    .pc    (cpu_pc),
    .halted(halted)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    cpu_reset = 1'b0;
    cpu_run   = 1'b0;
    dbg_req   = 1'b0;
    dbg_addr  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE) && (state != S_DONE);
    unique case (state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        if (start) nxt = S_PRE;
      end
      S_PRE: begin
        cpu_reset = 1'b1;
        nxt       = S_RUN;
      end
      S_RUN: begin
        cpu_run = 1'b1;
        if (halted || run_cnt == RUN_LAST) nxt = S_DREQ;
      end
      S_DREQ: begin
        dbg_req  = 1'b1;
        dbg_addr = idx;
        nxt      = S_DWAIT;
      end
      S_DWAIT: nxt = S_DOUT;
      S_DOUT: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready) nxt = at_last ? S_DONE : S_DREQ;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) nxt = S_PRE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt   <= '0;
      idx       <= '0;
      timeout   <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      unique case (state)
        S_PRE: begin
          run_cnt <= '0;
          timeout <= 1'b0;
          idx     <= IDX_BASE;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          // Halt takes priority over a coincident timeout.
          if (!halted && run_cnt == RUN_LAST) timeout <= 1'b1;
        end
        S_DWAIT: begin
          out_data  <= dbg_rdata;
          out_index <= idx;
        end
        S_DOUT: begin
          if (out_ready && !at_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a toy PC model and dmem model.
// Covers reset, halt, dump, backpressure, timeout, restart and mid-dump reset.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cpu_pc;
  logic        cpu_reset, cpu_run, dbg_req;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0]  out_index;
  logic        out_last, busy, done, timeout;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] pc = '0;
  logic        free = 1'b0;
  logic [31:0] ram [0:9];
  logic [31:0] fib [0:9];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .TIMEOUT(50)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cpu_pc   (cpu_pc),
    .cpu_reset(cpu_reset),
    .cpu_run  (cpu_run),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  assign cpu_pc = pc;

  always @(posedge clk) cyc <= cyc + 1;

  // Toy core: PC counts by 4 and self-loops at 100 unless free-running.
  always @(posedge clk) begin
    if (cpu_reset)
      pc <= '0;
    else if (cpu_run && (free || pc != 32'd100))
      pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (dbg_req) dbg_rdata <= ram[dbg_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int t100;
    int n;
    int w;
    int last_t;
    fib[0] = 1;  fib[1] = 1;  fib[2] = 2;  fib[3] = 3;  fib[4] = 5;
    fib[5] = 8;  fib[6] = 13; fib[7] = 21; fib[8] = 34; fib[9] = 55;
    for (int i = 0; i < 10; i++) ram[i] = fib[i];

    // Reset state
    tick(); tick();
    check("rst_cpu_reset", 32'(cpu_reset), 1);
    check("rst_cpu_run", 32'(cpu_run), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    tick();

    // Halt detection, with a stray start during RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_cpu_reset", 32'(cpu_reset), 1);
    check("pre_busy", 32'(busy), 1);
    tick();
    check("run_cpu_run", 32'(cpu_run), 1);
    t100 = -1;
    n = 0;
    while (cpu_run && n < 200) begin
      start = (n == 5);
      if (cpu_pc == 32'd100 && t100 < 0) t100 = n;
      tick();
      n++;
    end
    start = 1'b0;
    check("halt_latency", 32'(n - t100), 11);
    check("halt_timeout", 32'(timeout), 0);
    check("halt_dbg_req", 32'(dbg_req), 1);

    // Full dump with a 5-cycle stall at index 3
    last_t = 0;
    for (int b = 0; b < 10; b++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        tick();
        w++;
      end
      check("beat_valid", 32'(out_valid), 1);
      check("beat_index", 32'(out_index), 32'(b));
      check("beat_data", out_data, fib[b]);
      check("beat_last", 32'(out_last), 32'(b == 9));
      if (b > 0) check("beat_gap", 32'(cyc - last_t), (b == 4) ? 8 : 3);
      last_t = cyc;
      if (b == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_valid", 32'(out_valid), 1);
          check("stall_data", out_data, 3);
          check("stall_index", 32'(out_index), 3);
          check("stall_dbg_req", 32'(dbg_req), 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("dump_done", 32'(done), 1);
    check("dump_busy", 32'(busy), 0);
    check("dump_cpu_run", 32'(cpu_run), 0);
    check("dump_cpu_reset", 32'(cpu_reset), 0);
    check("dump_timeout", 32'(timeout), 0);

    // Restart from DONE into a free-running (timeout) run
    free = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("re_pre_cpu_reset", 32'(cpu_reset), 1);
    tick();
    check("re_run_cpu_reset", 32'(cpu_reset), 0);
    check("re_run_cpu_run", 32'(cpu_run), 1);
    n = 0;
    while (cpu_run && n < 200) begin
      tick();
      n++;
    end
    check("to_run_cycles", 32'(n), 50);
    check("to_timeout", 32'(timeout), 1);
    n = 0;
    w = 0;
    while (!done && w < 200) begin
      if (out_valid && out_ready) n++;
      tick();
      w++;
    end
    check("to_beats", 32'(n), 10);
    check("to_done", 32'(done), 1);
    check("to_timeout_hold", 32'(timeout), 1);

    // Reset during beat 4
    free = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!(out_valid && out_index == 8'd4) && w < 300) begin
      tick();
      w++;
    end
    check("mid_at_beat4", 32'(out_index), 4);
    reset = 1'b1;
    tick();
    check("mid_cpu_reset", 32'(cpu_reset), 1);
    check("mid_cpu_run", 32'(cpu_run), 0);
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_timeout", 32'(timeout), 0);
    check("mid_dbg_req", 32'(dbg_req), 0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
